stitched_add_pipeline: RTL and testbench
========================================

STITCHED_ADD_PIPELINE -- requirements
Module: stitched_add_pipeline

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; legal range 1..64.
REQ-002 Parameter STAGES, default 2: number of register stages between input and output; legal range 1..8.
REQ-003 Parameter SATURATE, default 0: 0 selects wrap-around sum, 1 selects unsigned saturating sum.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  the upstream operand pair is valid.
REQ-007 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-008 in_x  input  WIDTH  first unsigned operand.
REQ-009 in_y  input  WIDTH  second unsigned operand.
REQ-010 out_valid  output  1  out_sum and out_carry are valid.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_sum  output  WIDTH  sum result.
REQ-013 out_carry  output  1  carry-out of the unsigned add.
REQ-014 occupancy  output  clog2(STAGES+1)  number of valid stages currently held.

Function
REQ-015 A transfer at either port SHALL occur only in a cycle where both valid and ready are high at that port.
REQ-016 The sum SHALL be computed at WIDTH+1 bits as in_x + in_y before the first register stage. out_carry SHALL be bit WIDTH of that sum.
REQ-017 With SATURATE=0, out_sum SHALL be the low WIDTH bits of the sum. With SATURATE=1, out_sum SHALL be all ones whenever the carry is 1.
REQ-018 Each stage k SHALL hold one valid bit and a data register, and SHALL load from stage k-1 (the input for k=1) whenever it is empty or its contents leave this cycle.
REQ-019 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle). Stage 1 advancing SHALL itself ripple from the output side, so out_ready-to-in_ready is the only permitted combinational path.
REQ-020 Under continuous in_valid and out_ready, throughput SHALL be one result per cycle and latency exactly STAGES cycles from input transfer to out_valid.
REQ-021 Results SHALL leave in input order, with no drop and no duplication.
REQ-022 With out_valid=1 and out_ready=0, out_valid, out_sum and out_carry SHALL hold stable until transfer.
REQ-023 A full pipeline with out_ready=0 SHALL drive in_ready=0. An input presented while in_ready=0 SHALL NOT be captured.
REQ-024 A full pipeline with out_ready=1 SHALL accept a new input in the same cycle, and occupancy SHALL stay at STAGES.
REQ-025 Empty stages (bubbles) SHALL collapse: a stage that is not valid SHALL load regardless of downstream state.
REQ-026 occupancy SHALL be registered and SHALL equal the count of set stage valid bits. It SHALL change by +1, -1 or 0 per cycle according to the input and output transfers.
REQ-027 No output SHALL depend combinationally on in_x, in_y or in_valid.

Reset
REQ-028 Assertion of rst_n low SHALL immediately clear all valid bits, data registers and occupancy to 0, without waiting for a clock edge.
REQ-029 During reset, out_valid=0, out_sum=0, out_carry=0, occupancy=0 and in_ready=0.
REQ-030 In-flight results SHALL be discarded on reset with no partial output.
REQ-031 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Defaults, out_ready=1, one transfer of x=42 and y=64 -> out_valid exactly 2 cycles later with out_sum=106, out_carry=0, and occupancy 1 then 0.
REQ-033 Defaults, x=0xFFFFFFFF and y=1 -> out_sum=0x00000000, out_carry=1. With SATURATE=1 and the same inputs -> out_sum=0xFFFFFFFF, out_carry=1.
REQ-034 Backpressure: send pairs (1,2), (3,4), (5,6) with out_ready=0 -> occupancy=2 and in_ready=0. The third pair is held upstream, and out_sum=3 is stable for 5 cycles. Then raise out_ready -> outputs 3, 7, 11 on consecutive cycles.
REQ-035 Streaming: 100 back-to-back transfers with out_ready=1 -> 100 results in order, one per cycle, with no gap after the initial 2-cycle latency.
REQ-036 Reset mid-stream: drop rst_n with occupancy=2 between clock edges -> outputs and occupancy go to 0 before the next edge. No stale result appears after release.
REQ-037 WIDTH=8, STAGES=1: x=200, y=100 -> out_sum=44, out_carry=1, 1 cycle after transfer.

Source files
------------

// File: rtl/stitched_add_pipeline.sv
// stitched_add_pipeline
//
// Unsigned adder followed by a STAGES-deep valid/ready register pipeline.
// The (WIDTH+1)-bit sum is formed combinationally from the operands. Stage 1
// then captures either the wrapped sum or the saturated sum, together with
// the carry-out. Later stages forward that value unchanged. Empty stages
// always load, so bubbles collapse. The only combinational path from an
// input to an output is out_ready -> in_ready.
//
// Parameters
//   WIDTH    operand / sum width, 1..64
//   STAGES   register stages between input and output, 1..8
//   SATURATE 0: wrap-around sum, 1: unsigned saturating sum
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   operand pair accepted this cycle
//   in_x/in_y  unsigned operands
//   out_valid  out_sum/out_carry valid
//   out_ready  downstream accepts result
//   out_sum    sum result
//   out_carry  carry-out of the unsigned add
//   occupancy  number of valid stages held (registered)
module stitched_add_pipeline #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned SATURATE = 0,
  localparam int unsigned OccW    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [OccW-1:0]  occupancy
);

  localparam int unsigned LastIdx = STAGES - 1;

  // Each stage stores {carry, sum[WIDTH-1:0]}.
  logic [WIDTH:0]    sum_full;
  logic [WIDTH:0]    stage_in;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] load;
  logic [WIDTH:0]    data_q [STAGES];
  logic [WIDTH:0]    data_d [STAGES];
  logic [OccW-1:0]   occ_q, occ_d;
  logic              in_fire;
  logic              out_fire;

  // Adder and optional saturation ahead of the first register stage.
  always_comb begin
    sum_full = {1'b0, in_x} + {1'b0, in_y};
    stage_in = sum_full;
    if ((SATURATE != 0) && sum_full[WIDTH]) begin
      stage_in[WIDTH-1:0] = '1;
    end
  end

  // A stage may load when the downstream side can take its contents. From
  // stage s that holds when out_ready is high or some stage from s through
  // the last one is empty. Working this out from the output end means
  // load[0] depends only on out_ready and the registered valid bits.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    load      = '0;
    for (int s = int'(LastIdx); s >= 0; s--) begin
      tail_full = tail_full & valid_q[s];
      load[s]   = out_ready | ~tail_full;
    end
  end

  // Gating with rst_n keeps in_ready low while reset is held.
  assign in_ready = rst_n & load[0];
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q[LastIdx] & out_ready;

  // Stage next-state. The data registers update only when a valid item
  // arrives, so a stalled output stays stable.
  always_comb begin
    valid_d = valid_q;
    for (int s = 0; s < int'(STAGES); s++) begin
      data_d[s] = data_q[s];
    end

    if (load[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = stage_in;
      end
    end

    for (int s = 1; s < int'(STAGES); s++) begin
      if (load[s]) begin
        valid_d[s] = valid_q[s-1];
        if (valid_q[s-1]) begin
          data_d[s] = data_q[s-1];
        end
      end
    end
  end

  // Occupancy changes by at most one per cycle: +1 for an input transfer,
  // -1 for an output transfer, and no change when both or neither occur.
  always_comb begin
    occ_d = occ_q + OccW'(in_fire) - OccW'(out_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int s = 0; s < int'(STAGES); s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

  assign out_valid = valid_q[LastIdx];
  assign out_sum   = data_q[LastIdx][WIDTH-1:0];
  assign out_carry = data_q[LastIdx][WIDTH];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_stitched_add_pipeline.sv
// Self-checking bench for stitched_add_pipeline. It drives three instances
// from shared stimulus:
//   dut_a: defaults (WIDTH=32, STAGES=2, wrap-around sum)
//   dut_s: WIDTH=32, STAGES=2, saturating sum
//   dut_b: WIDTH=8, STAGES=1, fed from the low 8 bits of the operands
// The reference model holds a queue of accepted operand pairs per pipeline
// depth. The head of the queue is presented STAGES cycles after it was
// accepted and leaves when out_ready is high. The pipeline can accept a new
// pair when it has fewer than STAGES items or when out_ready is high.
module tb_stitched_add_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [7:0]  in_x_b;
  logic [7:0]  in_y_b;

  assign in_x_b = in_x[7:0];
  assign in_y_b = in_y[7:0];

  logic        in_ready_a, out_valid_a, out_carry_a;
  logic [31:0] out_sum_a;
  logic [1:0]  occ_a;
  logic        in_ready_s, out_valid_s, out_carry_s;
  logic [31:0] out_sum_s;
  logic [1:0]  occ_s;
  logic        in_ready_b, out_valid_b, out_carry_b;
  logic [7:0]  out_sum_b;
  logic [0:0]  occ_b;

  stitched_add_pipeline dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_sum   (out_sum_a),
    .out_carry (out_carry_a),
    .occupancy (occ_a)
  );

  stitched_add_pipeline #(
    .WIDTH    (32),
    .STAGES   (2),
    .SATURATE (1)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_sum   (out_sum_s),
    .out_carry (out_carry_s),
    .occupancy (occ_s)
  );

  stitched_add_pipeline #(
    .WIDTH    (8),
    .STAGES   (1),
    .SATURATE (0)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_x      (in_x_b),
    .in_y      (in_y_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_carry (out_carry_b),
    .occupancy (occ_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          t;
  } entry_t;

  entry_t q_a[$];
  entry_t q_b[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference sum: {carry, low bits}, computed with plain integer arithmetic.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input bit sat);
    longint unsigned mask;
    longint unsigned s;
    longint unsigned lo;
    logic            c;
    mask = (64'd1 << w) - 64'd1;
    s    = (longint'(x) & mask) + (longint'(y) & mask);
    c    = ((s >> w) & 64'd1) != 0;
    lo   = s & mask;
    if (sat && c) lo = mask;
    return {c, lo[31:0]};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then update the model at the rising edge.
  task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y, input bit ordy);
    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [32:0] e;
    @(negedge clk);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    out_ready = ordy;
    #1;
    rdy_a = (q_a.size() < 2) || ordy;
    vld_a = (q_a.size() > 0) && (cyc - q_a[0].t >= 2);
    rdy_b = (q_b.size() < 1) || ordy;
    vld_b = (q_b.size() > 0) && (cyc - q_b[0].t >= 1);

    check_eq("a_in_ready", in_ready_a, rdy_a);
    check_eq("a_out_valid", out_valid_a, vld_a);
    check_eq("a_occupancy", occ_a, q_a.size());
    check_eq("s_in_ready", in_ready_s, rdy_a);
    check_eq("s_out_valid", out_valid_s, vld_a);
    check_eq("s_occupancy", occ_s, q_a.size());
    if (vld_a) begin
      e = ref_add(q_a[0].x, q_a[0].y, 32, 1'b0);
      check_eq("a_out_sum", out_sum_a, e[31:0]);
      check_eq("a_out_carry", out_carry_a, e[32]);
      e = ref_add(q_a[0].x, q_a[0].y, 32, 1'b1);
      check_eq("s_out_sum", out_sum_s, e[31:0]);
      check_eq("s_out_carry", out_carry_s, e[32]);
    end

    check_eq("b_in_ready", in_ready_b, rdy_b);
    check_eq("b_out_valid", out_valid_b, vld_b);
    check_eq("b_occupancy", occ_b, q_b.size());
    if (vld_b) begin
      e = ref_add(q_b[0].x, q_b[0].y, 8, 1'b0);
      check_eq("b_out_sum", out_sum_b, e[7:0]);
      check_eq("b_out_carry", out_carry_b, e[32]);
    end

    @(posedge clk);
    if (vld_a && ordy) void'(q_a.pop_front());
    if (v && rdy_a) q_a.push_back('{x: x, y: y, t: cyc});
    if (vld_b && ordy) void'(q_b.pop_front());
    if (v && rdy_b) q_b.push_back('{x: x, y: y, t: cyc});
    cyc++;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_a_valid"}, out_valid_a, 1'b0);
    check_eq({tag, "_a_sum"}, out_sum_a, 32'd0);
    check_eq({tag, "_a_carry"}, out_carry_a, 1'b0);
    check_eq({tag, "_a_occ"}, occ_a, 2'd0);
    check_eq({tag, "_a_in_ready"}, in_ready_a, 1'b0);
    check_eq({tag, "_s_valid"}, out_valid_s, 1'b0);
    check_eq({tag, "_s_occ"}, occ_s, 2'd0);
    check_eq({tag, "_s_in_ready"}, in_ready_s, 1'b0);
    check_eq({tag, "_b_valid"}, out_valid_b, 1'b0);
    check_eq({tag, "_b_sum"}, out_sum_b, 8'd0);
    check_eq({tag, "_b_occ"}, occ_b, 1'b0);
    check_eq({tag, "_b_in_ready"}, in_ready_b, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'hFFFF_FFFF - $urandom_range(0, 3);
      1:       r = $urandom_range(0, 255);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    // Release mid high phase so the very next rising edge can transfer.
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single transfer 42 + 64.
    step(1'b1, 32'd42, 32'd64, 1'b1);
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Carry-out: wrap vs. saturate, and 8-bit 0xFF + 1.
    step(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1);

    // 8-bit overflow: 200 + 100.
    step(1'b1, 32'd200, 32'd100, 1'b1);
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Backpressure: third pair held upstream while the output stalls.
    step(1'b1, 32'd1, 32'd2, 1'b0);
    step(1'b1, 32'd3, 32'd4, 1'b0);
    repeat (5) step(1'b1, 32'd5, 32'd6, 1'b0);
    step(1'b1, 32'd5, 32'd6, 1'b1);
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Back-to-back streaming.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, rand_operand(), rand_operand(), 1'b1);
    end
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Random handshakes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), rand_operand(), rand_operand(),
           ($urandom_range(0, 2) != 0));
    end
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1);

    // Reset mid-stream with two items held.
    step(1'b1, 32'd10, 32'd20, 1'b0);
    step(1'b1, 32'd30, 32'd40, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid");
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    check_reset_state("mid_edge");
    #2 rst_n = 1'b1;
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 1) != 0), rand_operand(), rand_operand(),
           ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(1'b0, 32'd0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
